// File: rtl/wfi_pwr_seq_pkg.sv
// Shared power-sequencer definitions: state encoding and default PLL timing values.
// Also consumed by the power-status CSR, so the encoding must stay stable.
package wfi_pwr_seq_pkg;

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_GATE   = 3'd2;
  localparam logic [2:0] ST_SLEEP  = 3'd3;
  localparam logic [2:0] ST_RELOCK = 3'd4;
  localparam logic [2:0] ST_RESUME = 3'd5;

  typedef enum logic [2:0] {
    RUN    = ST_RUN,
    DRAIN  = ST_DRAIN,
    GATE   = ST_GATE,
    SLEEP  = ST_SLEEP,
    RELOCK = ST_RELOCK,
    RESUME = ST_RESUME
  } pwr_state_e;

  localparam int LOCK_STABLE_DEF  = 16;
  localparam int LOCK_TIMEOUT_DEF = 4096;
  localparam int GATE_SETTLE_DEF  = 2;

  function automatic logic clk_on(input pwr_state_e s);
    return (s == RUN) || (s == DRAIN) || (s == RESUME);
  endfunction

endpackage

// File: rtl/wfi_pwr_seq_lock_filter.sv
// PLL lock qualifier: 2-flop synchroniser plus consecutive-high counter; lock_ok once
// LOCK_STABLE synced highs are seen without a drop. clr holds the count at zero.
module wfi_pwr_seq_lock_filter #(
  parameter int LOCK_STABLE = 16
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic pll_lock,
  input  logic clr,
  output logic lock_ok
);

  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [STAB_W-1:0] stab_q, stab_d;

  always_comb begin
    sync1_d = pll_lock;
    sync2_d = sync1_q;
    stab_d  = stab_q;
    if (clr || !sync2_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_LAST) begin
      stab_d = stab_q + STAB_W'(1);
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stab_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      stab_q  <= stab_d;
    end
  end

  assign lock_ok = sync2_q && (stab_q == STAB_LAST);

endmodule

// File: rtl/wfi_pwr_seq.sv
// WFI sleep/wake sequencer owning core clock enable and PLL bypass; all outputs registered.
// Sleep: drain -> gate clock -> bypass PLL. Wake: release bypass -> stable lock -> ungate.
module wfi_pwr_seq
  import wfi_pwr_seq_pkg::*;
#(
  parameter int LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int GATE_SETTLE  = GATE_SETTLE_DEF
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic wfi_req,
  input  logic irq_pending,
  input  logic mem_busy,
  input  logic pll_lock,
  output logic pll_bypass,
  output logic core_clk_en,
  output logic wake,
  output logic sleeping,
  output logic lock_err
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_SETTLE - 1);

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             lock_err_q, lock_err_d;
  logic             pll_bypass_q, pll_bypass_d;
  logic             core_clk_en_q, core_clk_en_d;
  logic             wake_q, wake_d;
  logic             sleeping_q, sleeping_d;
  logic             lock_ok;
  logic             stab_clr;

  // Stability count only runs while actually waiting for relock.
  assign stab_clr = (state_q != RELOCK);

  wfi_pwr_seq_lock_filter #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_filter (
    .clk_ref (clk_ref),
    .rst     (rst),
    .pll_lock(pll_lock),
    .clr     (stab_clr),
    .lock_ok (lock_ok)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    lock_err_d = lock_err_q;
    wake_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (wfi_req) begin
          if (irq_pending) wake_d = 1'b1;
          else             state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (irq_pending) begin
          state_d = RUN;
          wake_d  = 1'b1;
        end else if (!mem_busy) begin
          state_d = GATE;
          cnt_d   = '0;
        end
      end
      GATE: begin
        if (cnt_q == GATE_LAST)  state_d = SLEEP;
        else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
      end
      SLEEP: begin
        if (irq_pending) begin
          // After a lock failure the PLL is abandoned; wake straight onto refclk.
          if (lock_err_q) begin
            state_d = RESUME;
          end else begin
            state_d = RELOCK;
            tmo_d   = '0;
          end
        end
      end
      RELOCK: begin
        if (lock_ok) begin
          state_d = RESUME;
        end else if (tmo_q == TMO_LAST) begin
          lock_err_d = 1'b1;
          state_d    = RESUME;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      RESUME:  state_d = RUN;
      default: state_d = RELOCK;
    endcase

    if (state_d == RESUME) wake_d = 1'b1;
    core_clk_en_d = clk_on(state_d);
    sleeping_d    = (state_d == GATE) || (state_d == SLEEP);
    pll_bypass_d  = (state_d == SLEEP) || lock_err_d;
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q       <= RELOCK;
      cnt_q         <= '0;
      tmo_q         <= '0;
      lock_err_q    <= 1'b0;
      pll_bypass_q  <= 1'b0;
      core_clk_en_q <= 1'b0;
      wake_q        <= 1'b0;
      sleeping_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      lock_err_q    <= lock_err_d;
      pll_bypass_q  <= pll_bypass_d;
      core_clk_en_q <= core_clk_en_d;
      wake_q        <= wake_d;
      sleeping_q    <= sleeping_d;
    end
  end

  assign pll_bypass  = pll_bypass_q;
  assign core_clk_en = core_clk_en_q;
  assign wake        = wake_q;
  assign sleeping    = sleeping_q;
  assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_wfi_pwr_seq.sv
// Bench for wfi_pwr_seq: scenario tasks with randomized drain lengths and lock patterns,
// relock exit predicted from a sliding-window view of the synchronised lock history.
module tb_wfi_pwr_seq;

  localparam int LS = 16;
  localparam int LT = 4096;
  localparam int GS = 2;

  logic clk_ref = 1'b0;
  logic rst, wfi_req, irq_pending, mem_busy, pll_lock;
  logic pll_bypass, core_clk_en, wake, sleeping, lock_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit lock_pat [0:LT-1];
  bit exp_lock_err = 1'b0;

  always #5 clk_ref = ~clk_ref;

  wfi_pwr_seq #(
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .GATE_SETTLE (GS)
  ) dut (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .wfi_req    (wfi_req),
    .irq_pending(irq_pending),
    .mem_busy   (mem_busy),
    .pll_lock   (pll_lock),
    .pll_bypass (pll_bypass),
    .core_clk_en(core_clk_en),
    .wake       (wake),
    .sleeping   (sleeping),
    .lock_err   (lock_err)
  );

  task automatic step();
    @(posedge clk_ref);
    #1;
  endtask

  // Relock cycle i sees the raw lock driven two cycles earlier; exit follows the first
  // run of LS synced highs, or the timeout after LT cycles, lock taking precedence.
  function automatic void predict(output int exit_c, output bit err);
    int run;
    bit s;
    run = 0;
    for (int i = 0; i < LT; i++) begin
      s = (i >= 2) ? lock_pat[i-2] : 1'b0;
      run = s ? run + 1 : 0;
      if (run >= LS) begin
        exit_c = i + 1;
        err = 1'b0;
        return;
      end
    end
    exit_c = LT;
    err = 1'b1;
  endfunction

  task automatic fill_random_pat();
    for (int i = 0; i < LT; i++)
      lock_pat[i] = (i < 40) ? ($urandom_range(0, 7) != 0) : 1'b1;
  endtask

  // Entered on the first RELOCK cycle; drives lock_pat and checks the exit cycle.
  task automatic relock_phase(input string name);
    int exit_c;
    bit err;
    bit early;
    logic [4:0] got, exp;
    predict(exit_c, err);
    early = 1'b0;
    for (int i = 0; i < exit_c; i++) begin
      pll_lock = lock_pat[i];
      if (core_clk_en !== 1'b0 || wake !== 1'b0 || pll_bypass !== 1'b0 ||
          sleeping !== 1'b0 || lock_err !== 1'b0) early = 1'b1;
      step();
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: outputs changed before cycle %0d, got early=%0b expected 0",
               name, exit_c, early);
    end
    exp_lock_err = err;
    pll_lock = !err;
    got = {core_clk_en, wake, pll_bypass, lock_err, sleeping};
    exp = {1'b1, 1'b1, err, err, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_resume: {clk_en,wake,bypass,lock_err,sleeping} got %b expected %b at cycle %0d",
               name, got, exp, exit_c);
    end
    step();
    got = {core_clk_en, wake, pll_bypass, lock_err, sleeping};
    exp = {1'b1, 1'b0, err, err, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_run: {clk_en,wake,bypass,lock_err,sleeping} got %b expected %b",
               name, got, exp);
    end
  endtask

  // Called in a RUN cycle; ends on the first SLEEP cycle.
  task automatic enter_sleep(input int m, input bit irq_in_gate);
    int dl;
    logic [3:0] got, exp;
    dl = (m == 0) ? 1 : m;
    wfi_req = 1'b1;
    irq_pending = 1'b0;
    mem_busy = (m > 0);
    pll_lock = 1'b0;
    for (int j = 1; j <= dl + GS + 1; j++) begin
      step();
      wfi_req = 1'b0;
      mem_busy = (j < m);
      if (irq_in_gate && j == dl + 1) irq_pending = 1'b1;
      got = {core_clk_en, sleeping, pll_bypass, wake};
      exp = {(j <= dl), (j > dl), ((j > dl + GS) || exp_lock_err), 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sleep_entry m=%0d j=%0d: {clk_en,sleeping,bypass,wake} got %b expected %b",
                 m, j, got, exp);
      end
    end
  endtask

  task automatic wake_from_sleep(input string name, input int k);
    logic [3:0] got, exp;
    for (int j = 0; j < k; j++) begin
      got = {core_clk_en, sleeping, pll_bypass, wake};
      n_checks++;
      if (got !== 4'b0110) begin
        n_fail++;
        $display("FAIL %s_sleep: {clk_en,sleeping,bypass,wake} got %b expected 0110", name, got);
      end
      step();
    end
    irq_pending = 1'b1;
    step();
    irq_pending = 1'b0;
    if (exp_lock_err) begin
      got = {core_clk_en, wake, pll_bypass, sleeping};
      exp = 4'b1110;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s_direct_resume: {clk_en,wake,bypass,sleeping} got %b expected %b",
                 name, got, exp);
      end
      step();
      got = {core_clk_en, wake, pll_bypass, sleeping};
      exp = 4'b1010;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s_direct_run: {clk_en,wake,bypass,sleeping} got %b expected %b",
                 name, got, exp);
      end
    end else begin
      relock_phase(name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wfi_req = 1'b0;
    irq_pending = 1'b0;
    mem_busy = 1'b0;
    pll_lock = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({pll_bypass, core_clk_en, wake, sleeping, lock_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected 00000",
               {pll_bypass, core_clk_en, wake, sleeping, lock_err});
    end
    rst = 1'b0;
    for (int i = 0; i < LT; i++) lock_pat[i] = (i >= 3);
    relock_phase("boot");
  endtask

  task automatic test_back_to_back();
    bit g;
    for (int it = 0; it < 5; it++) begin
      g = (it == 3);
      enter_sleep((it == 0) ? 5 : int'($urandom_range(0, 6)), g);
      fill_random_pat();
      wake_from_sleep("b2b", g ? 0 : int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_relock_glitch();
    enter_sleep(0, 1'b0);
    for (int i = 0; i < LT; i++) lock_pat[i] = (i != 10);
    wake_from_sleep("glitch", 1);
  endtask

  task automatic test_wfi_nop();
    logic [3:0] got;
    wfi_req = 1'b1;
    irq_pending = 1'b1;
    step();
    wfi_req = 1'b0;
    irq_pending = 1'b0;
    got = {core_clk_en, wake, sleeping, pll_bypass};
    n_checks++;
    if (got !== 4'b1100) begin
      n_fail++;
      $display("FAIL wfi_nop_pulse: {clk_en,wake,sleeping,bypass} got %b expected 1100", got);
    end
    step();
    got = {core_clk_en, wake, sleeping, pll_bypass};
    n_checks++;
    if (got !== 4'b1000) begin
      n_fail++;
      $display("FAIL wfi_nop_after: {clk_en,wake,sleeping,bypass} got %b expected 1000", got);
    end
  endtask

  task automatic test_drain_abort();
    int n;
    logic [2:0] got;
    n = $urandom_range(0, 3);
    wfi_req = 1'b1;
    mem_busy = 1'b1;
    irq_pending = 1'b0;
    step();
    wfi_req = 1'b0;
    for (int j = 0; j < n; j++) begin
      got = {core_clk_en, wake, sleeping};
      n_checks++;
      if (got !== 3'b100) begin
        n_fail++;
        $display("FAIL drain_hold: {clk_en,wake,sleeping} got %b expected 100", got);
      end
      step();
    end
    irq_pending = 1'b1;
    step();
    irq_pending = 1'b0;
    mem_busy = 1'b0;
    got = {core_clk_en, wake, sleeping};
    n_checks++;
    if (got !== 3'b110) begin
      n_fail++;
      $display("FAIL drain_abort_wake: {clk_en,wake,sleeping} got %b expected 110", got);
    end
    step();
    got = {core_clk_en, wake, sleeping};
    n_checks++;
    if (got !== 3'b100) begin
      n_fail++;
      $display("FAIL drain_abort_run: {clk_en,wake,sleeping} got %b expected 100", got);
    end
  endtask

  task automatic test_timeout_tie();
    enter_sleep($urandom_range(0, 4), 1'b0);
    for (int i = 0; i < LT; i++) lock_pat[i] = (i >= LT - 18) && (i <= LT - 3);
    wake_from_sleep("tmo_tie", 0);
  endtask

  task automatic test_timeout();
    enter_sleep($urandom_range(0, 4), 1'b0);
    for (int i = 0; i < LT; i++) lock_pat[i] = 1'b0;
    wake_from_sleep("tmo", 2);
  endtask

  task automatic test_fallback();
    enter_sleep($urandom_range(0, 4), 1'b0);
    wake_from_sleep("fallback", 1);
  endtask

  task automatic test_async_reset();
    enter_sleep(2, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pll_bypass, core_clk_en, wake, sleeping, lock_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: {bypass,clk_en,wake,sleeping,lock_err} got %b expected 00000",
               {pll_bypass, core_clk_en, wake, sleeping, lock_err});
    end
    exp_lock_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    fill_random_pat();
    relock_phase("post_rst");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_relock_glitch();
    test_wfi_nop();
    test_drain_abort();
    test_timeout_tie();
    test_timeout();
    test_fallback();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
